// File: rtl/comp_cic_seq_if.sv
// Sample handshake plus the tap-engine bus (coefficient address, delayed sample,
// accumulator strobes and read-back) between comp_cic_seq and the MAC/ROM.
interface comp_cic_seq_if #(
  parameter int Win    = 16,
  parameter int Waccum = 34,
  parameter int Wout   = 16,
  parameter int NTAPS  = 32
);
  localparam int AW = $clog2(NTAPS);

  logic                     ic_valid_in;
  logic signed [Win-1:0]    id_in;
  logic                     oc_ready;
  logic                     oc_drop;
  logic [AW-1:0]            oc_addr_coef;
  logic signed [Win-1:0]    od_reg_desp;
  logic                     oc_en_acc;
  logic                     oc_rst_acc;
  logic signed [Waccum-1:0] id_accum;
  logic signed [Wout-1:0]   od_out;
  logic                     oc_valid_out;

  modport master (
    output ic_valid_in, id_in, id_accum,
    input  oc_ready, oc_drop, oc_addr_coef, od_reg_desp,
           oc_en_acc, oc_rst_acc, od_out, oc_valid_out
  );

  modport slave (
    input  ic_valid_in, id_in, id_accum,
    output oc_ready, oc_drop, oc_addr_coef, od_reg_desp,
           oc_en_acc, oc_rst_acc, od_out, oc_valid_out
  );
endinterface

// File: rtl/comp_cic_seq.sv
// Tap sequencer for the CIC compensation FIR: keeps the sample history, walks all
// taps through the external MAC, then rounds/saturates the accumulator to one output.
module comp_cic_seq #(
  parameter int Win    = 16,
  parameter int Wcoef  = 18,
  parameter int Waccum = 34,
  parameter int Wout   = 16,
  parameter int NTAPS  = 32,
  parameter int SHIFT  = 17
) (
  input  logic          clk,
  input  logic          rst,
  comp_cic_seq_if.slave bus
);
  localparam int AW = $clog2(NTAPS);
  localparam logic signed [Waccum:0] HALF = {{Waccum{1'b0}}, 1'b1} << (SHIFT - 1);

  if ((NTAPS < 4) || ((NTAPS & (NTAPS - 1)) != 0)) begin : g_bad_ntaps
    $error("comp_cic_seq: NTAPS must be a power of two >= 4");
  end
  if ((Win + Wcoef > Waccum) || (SHIFT < 1) || (SHIFT >= Waccum)) begin : g_bad_widths
    $error("comp_cic_seq: inconsistent Win/Wcoef/Waccum/SHIFT");
  end

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, CAPT} state_t;

  state_t                  state, state_nx;
  logic [AW-1:0]           wr_ptr, base, tap, rd_ptr;
  logic [AW:0]             fill;
  logic signed [Win-1:0]   hist [NTAPS];
  logic                    accept, last_tap;
  logic signed [Waccum:0]  acc_ext, rnd;
  logic signed [Wout-1:0]  sat;

  assign accept           = (state == IDLE) && bus.ic_valid_in;
  assign last_tap         = (tap == AW'(NTAPS - 1));
  assign rd_ptr           = base - tap;
  assign bus.oc_addr_coef = tap;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.ic_valid_in) state_nx = RUN;
      RUN:     if (last_tap) state_nx = FLUSH;
      FLUSH:   state_nx = CAPT;
      CAPT:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One guard bit so adding the half-LSB cannot wrap before the shift.
  always_comb begin
    acc_ext = {bus.id_accum[Waccum-1], bus.id_accum};
    rnd     = (acc_ext + HALF) >>> SHIFT;
    if ((rnd[Waccum:Wout-1] == '0) || (rnd[Waccum:Wout-1] == '1))
      sat = rnd[Wout-1:0];
    else
      sat = rnd[Waccum] ? {1'b1, {(Wout-1){1'b0}}} : {1'b0, {(Wout-1){1'b1}}};
  end

  // History RAM is not reset; fill=0 masks stale entries instead.
  always_ff @(posedge clk) begin
    if (accept) hist[wr_ptr] <= bus.id_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      wr_ptr           <= '0;
      base             <= '0;
      fill             <= '0;
      tap              <= '0;
      bus.oc_ready     <= 1'b1;
      bus.oc_drop      <= 1'b0;
      bus.oc_rst_acc   <= 1'b0;
      bus.oc_en_acc    <= 1'b0;
      bus.od_reg_desp  <= '0;
      bus.od_out       <= '0;
      bus.oc_valid_out <= 1'b0;
    end else begin
      state            <= state_nx;
      bus.oc_ready     <= (state_nx == IDLE);
      // Registered, so the pulse trails the rejected strobe by one cycle.
      bus.oc_drop      <= bus.ic_valid_in && (state != IDLE);
      bus.oc_rst_acc   <= accept;
      bus.oc_en_acc    <= (state == RUN);
      bus.oc_valid_out <= (state == CAPT);

      if (accept) begin
        base   <= wr_ptr;
        wr_ptr <= wr_ptr + 1'b1;
        tap    <= '0;
        if (fill != (AW+1)'(NTAPS)) fill <= fill + 1'b1;
      end else if (state == RUN) begin
        tap <= tap + 1'b1;
      end

      // Sample leaves one cycle after its address, lining up with the ROM read.
      if (state == RUN)
        bus.od_reg_desp <= ({1'b0, tap} < fill) ? hist[rd_ptr] : '0;

      if (state == CAPT) bus.od_out <= sat;
    end
  end
endmodule

// File: tb/tb_comp_cic_seq.sv
// Bench for comp_cic_seq: ROM/MAC models, cycle-timing model, and a queue-based
// scoreboard fed by a direct-form FIR reference.
module tb_comp_cic_seq;
  localparam int Win = 16, Wcoef = 18, Waccum = 34, Wout = 16, NTAPS = 32, SHIFT = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  comp_cic_seq_if #(.Win(Win), .Waccum(Waccum), .Wout(Wout), .NTAPS(NTAPS)) bus ();

  comp_cic_seq #(.Win(Win), .Wcoef(Wcoef), .Waccum(Waccum), .Wout(Wout),
                 .NTAPS(NTAPS), .SHIFT(SHIFT)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Coefficient ROM (1-cycle read) and MAC
  logic signed [Wcoef-1:0]  h [NTAPS];
  logic signed [Wcoef-1:0]  rom_q = '0;
  logic signed [Waccum-1:0] mac = '0;
  always @(posedge clk) begin
    rom_q <= h[bus.oc_addr_coef];
    if (bus.oc_rst_acc)     mac <= '0;
    else if (bus.oc_en_acc) mac <= mac + Waccum'(rom_q) * Waccum'(bus.od_reg_desp);
  end
  assign bus.id_accum = mac;

  int tests = 0, fails = 0;
  int cyc = 0, busy_until = -1, acc_cyc = -1000;
  bit drop_exp = 1'b0;
  int hist[$];
  logic signed [Wout-1:0] exp_q[$];
  logic signed [Wout-1:0] last_out = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  // y[n] = sum_k h[k]*x[n-k] over samples since reset, rounded and clamped
  function automatic logic signed [Wout-1:0] ref_out();
    longint acc = 0;
    longint r;
    int n = hist.size() - 1;
    for (int k = 0; k < NTAPS; k++)
      if (n - k >= 0) acc += longint'(h[k]) * longint'(hist[n-k]);
    r = (acc + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    if (r > (longint'(1) <<< (Wout - 1)) - 1) r = (longint'(1) <<< (Wout - 1)) - 1;
    if (r < -(longint'(1) <<< (Wout - 1)))    r = -(longint'(1) <<< (Wout - 1));
    return Wout'(r);
  endfunction

  // Acceptance / timing model
  always @(posedge clk) begin
    if (rst) begin
      busy_until = -1; acc_cyc = -1000; drop_exp = 1'b0;
      hist.delete(); exp_q.delete(); last_out = '0;
    end else begin
      drop_exp = 1'b0;
      if (bus.ic_valid_in) begin
        if (cyc > busy_until) begin
          acc_cyc    = cyc;
          busy_until = cyc + NTAPS + 2;
          hist.push_back(int'(bus.id_in));
          exp_q.push_back(ref_out());
        end else drop_exp = 1'b1;
      end
    end
    cyc++;
    #1;
    chk("ready",   bus.oc_ready,     cyc > busy_until);
    chk("drop",    bus.oc_drop,      drop_exp);
    chk("rst_acc", bus.oc_rst_acc,   cyc == acc_cyc + 1);
    chk("en_acc",  bus.oc_en_acc,    (cyc >= acc_cyc + 2) && (cyc <= acc_cyc + NTAPS + 1));
    chk("valid",   bus.oc_valid_out, cyc == acc_cyc + NTAPS + 3);
    if ((cyc >= acc_cyc + 1) && (cyc <= acc_cyc + NTAPS))
      chk("addr", bus.oc_addr_coef, cyc - acc_cyc - 1);
  end

  // Output monitor / scoreboard
  always @(posedge clk) begin
    #1;
    if (!rst && bus.oc_valid_out) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out cyc=%0d got=%0h exp=none", cyc, bus.od_out);
      end else begin
        last_out = exp_q.pop_front();
        chk("od_out", bus.od_out, last_out);
      end
    end else chk("od_hold", bus.od_out, last_out);
  end

  task automatic send(input logic signed [Win-1:0] x);
    int n = 0;
    @(negedge clk);
    while (!bus.oc_ready && n < 200) begin @(negedge clk); n++; end
    if (!bus.oc_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout cyc=%0d got=busy exp=ready", cyc);
    end
    bus.ic_valid_in = 1'b1;
    bus.id_in       = x;
    @(negedge clk);
    bus.ic_valid_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !bus.oc_ready) && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) begin
      tests++; fails++;
      $display("FAIL drain_timeout cyc=%0d got=%0d pending exp=0", cyc, exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_coef(input int v);
    for (int k = 0; k < NTAPS; k++) h[k] = Wcoef'(v);
  endtask

  task automatic rand_coef();
    int t;
    for (int k = 0; k < NTAPS; k++) begin
      t = int'($urandom_range(0, 8191)) - 4096;
      h[k] = Wcoef'(t);
    end
  endtask

  task automatic rand_traffic(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      bus.ic_valid_in = ($urandom_range(0, 5) == 0);
      bus.id_in       = Win'($urandom);
    end
    @(negedge clk);
    bus.ic_valid_in = 1'b0;
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1);
  end

  initial begin
    bus.ic_valid_in = 1'b0;
    bus.id_in       = '0;
    set_coef(0);
    repeat (3) @(negedge clk);
    chk("reset_out",   bus.od_out,   0);
    chk("reset_ready", bus.oc_ready, 1);
    rst = 1'b0;

    // Control timing, single sample with flat coefficients
    set_coef(32'h100);
    send(16'sh0100);
    drain();
    chk("t1_out", bus.od_out, 1);

    // Reset mid-run, then the same scenario must give the same answer
    send(16'sh0100);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mr_ready", bus.oc_ready,     1);
    chk("mr_en",    bus.oc_en_acc,    0);
    chk("mr_clr",   bus.oc_rst_acc,   0);
    chk("mr_valid", bus.oc_valid_out, 0);
    chk("mr_out",   bus.od_out,       0);
    chk("mr_desp",  bus.od_reg_desp,  0);
    chk("mr_addr",  bus.oc_addr_coef, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send(16'sh0100);
    drain();
    chk("mr_repeat", bus.od_out, 1);

    // Positive then negative saturation
    do_reset();
    set_coef(0);
    for (int k = 0; k < 3; k++) h[k] = 18'sh10000;
    repeat (3) send(16'sh7FFF);
    drain();
    chk("sat_pos", bus.od_out, 32767);
    repeat (3) send(-16'sh8000);
    drain();
    chk("sat_neg", bus.od_out, -32768);

    // History wrap: only the oldest tap is non-zero
    do_reset();
    set_coef(0);
    h[NTAPS-1] = 18'sh10000;
    for (int m = 0; m < 40; m++) send(Win'(2 * (m + 1)));
    drain();
    chk("wrap_last", bus.od_out, 9);

    // Drop: extra strobe in cycle 10 of a run
    rand_coef();
    send(Win'($urandom));
    repeat (9) @(negedge clk);
    bus.ic_valid_in = 1'b1;
    bus.id_in       = Win'($urandom);
    @(negedge clk);
    bus.ic_valid_in = 1'b0;
    drain();
    send(Win'($urandom));
    drain();

    // Randomized traffic with frequent strobes while busy
    rand_traffic(2500);
    rand_coef();
    rand_traffic(2500);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
